// File: rtl/grid_mem_arbiter.sv
// Single-port arbiter for the 16x16 game-grid RAM: VGA reads, two round-robin writers, starvation guard.
// Define CLEAR_ON_RESET_EN to sweep CLEAR_VALUE through every cell after reset.
module grid_mem_arbiter #(
    parameter int              X_W          = 4,
    parameter int              Y_W          = 4,
    parameter int              D_W          = 2,
    parameter int              STARVE_LIMIT = 8,
    parameter logic [D_W-1:0]  CLEAR_VALUE  = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vga_req,
    input  logic [X_W-1:0]     vga_x,
    input  logic [Y_W-1:0]     vga_y,
    output logic [D_W-1:0]     vga_rdata,
    output logic               vga_rvalid,
    output logic               vga_miss,
    input  logic               wr0_req,
    input  logic [X_W-1:0]     wr0_x,
    input  logic [Y_W-1:0]     wr0_y,
    input  logic [D_W-1:0]     wr0_data,
    output logic               wr0_gnt,
    input  logic               wr1_req,
    input  logic [X_W-1:0]     wr1_x,
    input  logic [Y_W-1:0]     wr1_y,
    input  logic [D_W-1:0]     wr1_data,
    output logic               wr1_gnt,
    output logic [Y_W+X_W-1:0] mem_addr,
    output logic               mem_we,
    output logic [D_W-1:0]     mem_wdata,
    input  logic [D_W-1:0]     mem_rdata,
    output logic               busy
);
    localparam int         A_W   = Y_W + X_W;
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic           run, clearing;
    logic [A_W-1:0] clr_addr;
    logic           gnt0, gnt1, vga_gnt, starved0, starved1;
    logic           rr_last_q, rr_last_d;
    logic [7:0]     wait0_q, wait0_d, wait1_q, wait1_d;
    logic           vga_rvalid_q, vga_rvalid_d;

`ifdef CLEAR_ON_RESET_EN
    typedef enum logic {ST_CLEAR, ST_RUN} state_e;
    state_e         state_q, state_d;
    logic [A_W-1:0] clr_addr_q, clr_addr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == ST_CLEAR) begin
            clr_addr_d = clr_addr_q + A_W'(1);
            if (&clr_addr_q) state_d = ST_RUN;
        end
    end

    assign run      = (state_q == ST_RUN) && !reset;
    assign clearing = (state_q == ST_CLEAR) && !reset;
    assign clr_addr = clr_addr_q;
`else
    assign run      = !reset;
    assign clearing = 1'b0;
    assign clr_addr = '0;
`endif

    // Reset also gates the grants, so every output reads 0 while reset is held.
    assign starved0 = wr0_req && (wait0_q == LIMIT);
    assign starved1 = wr1_req && (wait1_q == LIMIT);

    // NOTE: every variable gets a default before the if-chain, so no path infers a latch.
    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        vga_gnt = 1'b0;
        if (run) begin
            if (starved0 && starved1) begin
                gnt0 = rr_last_q;
                gnt1 = !rr_last_q;
            end else if (starved0) begin
                gnt0 = 1'b1;
            end else if (starved1) begin
                gnt1 = 1'b1;
            end else if (vga_req) begin
                vga_gnt = 1'b1;
            end else if (wr0_req && wr1_req) begin
                gnt0 = rr_last_q;
                gnt1 = !rr_last_q;
            end else begin
                gnt0 = wr0_req;
                gnt1 = wr1_req;
            end
        end
    end

    always_comb begin
        rr_last_d    = gnt0 ? 1'b0 : (gnt1 ? 1'b1 : rr_last_q);
        vga_rvalid_d = vga_gnt;
        wait0_d      = '0;
        wait1_d      = '0;
        if (run && wr0_req && !gnt0) wait0_d = (wait0_q == LIMIT) ? wait0_q : wait0_q + 8'd1;
        if (run && wr1_req && !gnt1) wait1_d = (wait1_q == LIMIT) ? wait1_q : wait1_q + 8'd1;
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last_q    <= 1'b1;
            wait0_q      <= '0;
            wait1_q      <= '0;
            vga_rvalid_q <= 1'b0;
        end else begin
            rr_last_q    <= rr_last_d;
            wait0_q      <= wait0_d;
            wait1_q      <= wait1_d;
            vga_rvalid_q <= vga_rvalid_d;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (clearing) begin
            mem_addr  = clr_addr;
            mem_we    = 1'b1;
            mem_wdata = CLEAR_VALUE;
        end else if (gnt0) begin
            mem_addr  = {wr0_y, wr0_x};
            mem_we    = 1'b1;
            mem_wdata = wr0_data;
        end else if (gnt1) begin
            mem_addr  = {wr1_y, wr1_x};
            mem_we    = 1'b1;
            mem_wdata = wr1_data;
        end else if (vga_gnt) begin
            mem_addr  = {vga_y, vga_x};
        end
    end

    assign wr0_gnt    = gnt0;
    assign wr1_gnt    = gnt1;
    assign vga_miss   = run && vga_req && !vga_gnt;
    assign vga_rvalid = vga_rvalid_q;
    assign vga_rdata  = vga_rvalid_q ? mem_rdata : '0;
    assign busy       = clearing;

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Scoreboard bench for grid_mem_arbiter with a synchronous-read RAM model.
// Runs the clear-sweep scenario when CLEAR_ON_RESET_EN is defined.
module tb_grid_mem_arbiter;
    localparam int         LIMIT   = 8;
    localparam logic [1:0] CLR_VAL = 2'd2;

    logic       clk = 1'b0;
    logic       reset;
    logic       vga_req, vga_rvalid, vga_miss;
    logic [3:0] vga_x, vga_y, wr0_x, wr0_y, wr1_x, wr1_y;
    logic [1:0] vga_rdata, wr0_data, wr1_data, mem_wdata, mem_rdata;
    logic       wr0_req, wr1_req, wr0_gnt, wr1_gnt, mem_we, busy;
    logic [7:0] mem_addr;

    always #5 clk = ~clk;

    grid_mem_arbiter #(
        .X_W(4), .Y_W(4), .D_W(2), .STARVE_LIMIT(LIMIT), .CLEAR_VALUE(CLR_VAL)
    ) dut (
        .clk(clk), .reset(reset),
        .vga_req(vga_req), .vga_x(vga_x), .vga_y(vga_y),
        .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid), .vga_miss(vga_miss),
        .wr0_req(wr0_req), .wr0_x(wr0_x), .wr0_y(wr0_y), .wr0_data(wr0_data), .wr0_gnt(wr0_gnt),
        .wr1_req(wr1_req), .wr1_x(wr1_x), .wr1_y(wr1_y), .wr1_data(wr1_data), .wr1_gnt(wr1_gnt),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // RAM model with a back-door preload port
    logic [1:0] ram [256];
    logic       pre_we;
    logic [7:0] pre_addr;
    logic [1:0] pre_data;
    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct packed {
        logic g0, g1, miss, we, rv, busy;
        logic [7:0] addr;
    } obs_t;

    obs_t       exp_q [$];
    logic [1:0] wd_q  [$];
    logic [1:0] rd_q  [$];
    int         n_tests, n_fail;

    function automatic obs_t sample();
        obs_t o;
        o.g0 = wr0_gnt; o.g1 = wr1_gnt; o.miss = vga_miss; o.we = mem_we;
        o.rv = vga_rvalid; o.busy = busy; o.addr = mem_addr;
        return o;
    endfunction

    function automatic obs_t exp_rd(logic [7:0] a, logic rv);
        obs_t e = '0;
        e.rv = rv; e.addr = a;
        return e;
    endfunction

    function automatic obs_t exp_wr(bit w, logic [7:0] a, logic miss, logic rv);
        obs_t e = '0;
        e.g0 = !w; e.g1 = w; e.we = 1'b1; e.miss = miss; e.rv = rv; e.addr = a;
        return e;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("g0=%b g1=%b miss=%b we=%b rv=%b busy=%b addr=%h",
                         o.g0, o.g1, o.miss, o.we, o.rv, o.busy, o.addr);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_run();
        int n = 0;
        #1;
        while (busy === 1'b1 && n < 300) begin
            tick();
            n++;
        end
        n_tests++;
        if (n >= 300) begin
            n_fail++;
            $display("FAIL wait_run: busy still %b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic test_reset();
        tick();
        reset = 1'b1;
        vga_req = 1'b1; vga_x = 4'd3; vga_y = 4'd5;
        wr0_req = 1'b1; wr0_x = 4'd1; wr0_y = 4'd2; wr0_data = 2'd3;
        wr1_req = 1'b1; wr1_x = 4'd4; wr1_y = 4'd6; wr1_data = 2'd1;
        tick();
        tick();
        @(negedge clk);
        n_tests++;
        if ({wr0_gnt, wr1_gnt, vga_miss, vga_rvalid} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got gnt0/gnt1/miss/rv=%b%b%b%b, required 0000", wr0_gnt, wr1_gnt, vga_miss, vga_rvalid);
        end
        n_tests++;
        if ({mem_we, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_mem: got we=%b addr=%h wd=%h, required all 0", mem_we, mem_addr, mem_wdata);
        end
        n_tests++;
        if ({busy, vga_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_misc: got busy=%b rdata=%h, required 0", busy, vga_rdata);
        end
        tick();
        reset = 1'b0; vga_req = 1'b0; wr0_req = 1'b0; wr1_req = 1'b0;
        wait_run();
    endtask

`ifdef CLEAR_ON_RESET_EN
    task automatic test_clear();
        obs_t o, e;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vga_req = 1'b1; vga_x = 4'd3; vga_y = 4'd5;
        wr0_req = 1'b1; wr1_req = 1'b1;
        for (int i = 0; i < 256; i++) begin
            e = '0; e.we = 1'b1; e.busy = 1'b1; e.addr = 8'(i);
            exp_q.push_back(e);
            @(negedge clk);
            o = sample(); e = exp_q.pop_front(); n_tests++;
            if ({o, mem_wdata} !== {e, CLR_VAL}) begin
                n_fail++;
                $display("FAIL clear[%0d]: got %s wd=%h, expected %s wd=%h", i, fmt(o), mem_wdata, fmt(e), CLR_VAL);
            end
            tick();
        end
        exp_q.push_back(exp_rd(8'h53, 1'b0));
        @(negedge clk);
        o = sample(); e = exp_q.pop_front(); n_tests++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL clear_first_run: got %s, expected %s", fmt(o), fmt(e));
        end
        tick();
        vga_req = 1'b0; wr0_req = 1'b0; wr1_req = 1'b0;
        exp_q.push_back(exp_rd(8'h00, 1'b1));
        @(negedge clk);
        o = sample(); e = exp_q.pop_front(); n_tests++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL clear_idle: got %s, expected %s", fmt(o), fmt(e));
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int j = 0; j < 8'h40; j++) tick();
        @(negedge clk);
        n_tests++;
        if ({busy, mem_addr} !== {1'b1, 8'h40}) begin
            n_fail++;
            $display("FAIL clear_mid: got busy=%b addr=%h, required busy=1 addr=40", busy, mem_addr);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({busy, mem_we, mem_addr} !== {1'b1, 1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL clear_restart: got busy=%b we=%b addr=%h, required 1 1 00", busy, mem_we, mem_addr);
        end
        tick();
        wait_run();
    endtask
`endif

    task automatic test_vga_reads(string tag, int n, logic [7:0] a [8], logic [1:0] d [8], bit preload);
        obs_t o, e;
        logic [1:0] xd;
        if (preload) begin
            for (int i = 0; i < n; i++) begin
                pre_we = 1'b1; pre_addr = a[i]; pre_data = d[i];
                tick();
            end
            pre_we = 1'b0;
        end
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                vga_req = 1'b1; vga_x = a[i][3:0]; vga_y = a[i][7:4];
                exp_q.push_back(exp_rd(a[i], i > 0));
                rd_q.push_back(d[i]);
            end else begin
                vga_req = 1'b0; vga_x = 4'd0; vga_y = 4'd0;
                exp_q.push_back(exp_rd(8'h00, 1'b1));
            end
            @(negedge clk);
            o = sample(); e = exp_q.pop_front(); n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s[%0d]: got %s, expected %s", tag, i, fmt(o), fmt(e));
            end
            if (i > 0) begin
                xd = rd_q.pop_front(); n_tests++;
                if (vga_rdata !== xd) begin
                    n_fail++;
                    $display("FAIL %s_data[%0d]: got %h, expected %h", tag, i - 1, vga_rdata, xd);
                end
            end
            tick();
        end
    endtask

    task automatic test_vga_read();
        logic [7:0] a [8] = '{8'h53, 8'hA1, 8'h0F, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [1:0] d [8] = '{2'd2, 2'd3, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
        test_vga_reads("vga_read", 4, a, d, 1'b1);
    endtask

    task automatic test_round_robin();
        obs_t o, e;
        logic [1:0] wd;
        bit w;
        logic g0_seen, g1_seen;
        vga_req = 1'b0;
        wr0_x = 4'd1; wr0_y = 4'd1; wr0_data = 2'd1;
        wr1_x = 4'd2; wr1_y = 4'd2; wr1_data = 2'd2;
        wr0_req = 1'b1; wr1_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 6) wr0_req = 1'b0;
            w = (i >= 6) ? 1'b1 : bit'(i % 2);
            exp_q.push_back(exp_wr(w, w ? {wr1_y, wr1_x} : {wr0_y, wr0_x}, 1'b0, 1'b0));
            wd_q.push_back(w ? wr1_data : wr0_data);
            @(negedge clk);
            o = sample(); e = exp_q.pop_front(); wd = wd_q.pop_front(); n_tests++;
            if (o !== e || mem_wdata !== wd) begin
                n_fail++;
                $display("FAIL rr[%0d]: got %s wd=%h, expected %s wd=%h", i, fmt(o), mem_wdata, fmt(e), wd);
            end
            g0_seen = wr0_gnt; g1_seen = wr1_gnt;
            tick();
            if (g0_seen) wr0_x++;
            if (g1_seen) wr1_x++;
        end
        wr0_req = 1'b0; wr1_req = 1'b0;
        exp_q.push_back(exp_rd(8'h00, 1'b0));
        @(negedge clk);
        o = sample(); e = exp_q.pop_front(); n_tests++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL rr_idle: got %s, expected %s", fmt(o), fmt(e));
        end
        tick();
    endtask

    task automatic test_vga_priority();
        obs_t o, e;
        logic [1:0] wd;
        vga_req = 1'b1; vga_x = 4'd0; vga_y = 4'd0;
        wr1_req = 1'b1; wr1_x = 4'd2; wr1_y = 4'd7; wr1_data = 2'd1;
        for (int i = 1; i <= 11; i++) begin
            if (i <= 8) exp_q.push_back(exp_rd(8'h00, i > 1));
            else if (i == 9) begin
                exp_q.push_back(exp_wr(1'b1, 8'h72, 1'b1, 1'b1));
                wd_q.push_back(2'd1);
            end else if (i == 10) exp_q.push_back(exp_rd(8'h00, 1'b0));
            else exp_q.push_back(exp_rd(8'h00, 1'b1));
            @(negedge clk);
            o = sample(); e = exp_q.pop_front(); n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL prio[%0d]: got %s, expected %s", i, fmt(o), fmt(e));
            end
            if (i == 9) begin
                wd = wd_q.pop_front(); n_tests++;
                if (mem_wdata !== wd) begin
                    n_fail++;
                    $display("FAIL prio_wdata: got %h, expected %h", mem_wdata, wd);
                end
            end
            tick();
            if (i == 9) wr1_req = 1'b0;
            if (i == 10) vga_req = 1'b0;
        end
    endtask

    task automatic test_both_starved();
        obs_t o, e;
        vga_req = 1'b1; vga_x = 4'd0; vga_y = 4'd0;
        wr0_req = 1'b1; wr0_x = 4'd4; wr0_y = 4'd9; wr0_data = 2'd3;
        wr1_req = 1'b1; wr1_x = 4'd5; wr1_y = 4'd9; wr1_data = 2'd2;
        for (int i = 1; i <= 12; i++) begin
            if (i <= 8) exp_q.push_back(exp_rd(8'h00, i > 1));
            else if (i == 9) exp_q.push_back(exp_wr(1'b0, 8'h94, 1'b1, 1'b1));
            else if (i == 10) exp_q.push_back(exp_wr(1'b1, 8'h95, 1'b1, 1'b0));
            else if (i == 11) exp_q.push_back(exp_rd(8'h00, 1'b0));
            else exp_q.push_back(exp_rd(8'h00, 1'b1));
            @(negedge clk);
            o = sample(); e = exp_q.pop_front(); n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL starve2[%0d]: got %s, expected %s", i, fmt(o), fmt(e));
            end
            tick();
            if (i == 9) wr0_req = 1'b0;
            if (i == 10) wr1_req = 1'b0;
            if (i == 11) vga_req = 1'b0;
        end
    endtask

    task automatic test_readback();
        logic [7:0] a [8] = '{8'h11, 8'h13, 8'h22, 8'h26, 8'h72, 8'h94, 8'h95, 8'h00};
        logic [1:0] d [8] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd3, 2'd2, 2'd0};
        test_vga_reads("readback", 7, a, d, 1'b0);
    endtask

    task automatic test_reset_mid();
        obs_t o, e;
        vga_req = 1'b0;
        wr0_req = 1'b1; wr0_x = 4'd0; wr0_y = 4'd3; wr0_data = 2'd1;
        exp_q.push_back(exp_wr(1'b0, 8'h30, 1'b0, 1'b0));
        @(negedge clk);
        o = sample(); e = exp_q.pop_front(); n_tests++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL rmid_pre: got %s, expected %s", fmt(o), fmt(e));
        end
        tick();
        wr0_x = 4'd1; wr0_data = 2'd2;
        wr1_req = 1'b1; wr1_x = 4'd6; wr1_y = 4'd3; wr1_data = 2'd3;
        vga_req = 1'b1; vga_x = 4'd0; vga_y = 4'd0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        n_tests++;
        if ({wr0_gnt, wr1_gnt, vga_miss, vga_rvalid, mem_we, mem_addr, mem_wdata, busy, vga_rdata} !== '0) begin
            n_fail++;
            $display("FAIL rmid_outputs: got g0=%b g1=%b miss=%b rv=%b we=%b addr=%h wd=%h busy=%b rd=%h, required all 0",
                     wr0_gnt, wr1_gnt, vga_miss, vga_rvalid, mem_we, mem_addr, mem_wdata, busy, vga_rdata);
        end
        tick();
        reset = 1'b0; vga_req = 1'b0;
        wait_run();
        for (int i = 1; i <= 10; i++) begin
            if (i == 1) exp_q.push_back(exp_wr(1'b0, 8'h31, 1'b0, 1'b0));
            else if (i <= 8) exp_q.push_back(exp_rd(8'h00, i > 2));
            else if (i == 9) exp_q.push_back(exp_wr(1'b1, 8'h36, 1'b1, 1'b1));
            else exp_q.push_back(exp_rd(8'h00, 1'b0));
            @(negedge clk);
            o = sample(); e = exp_q.pop_front(); n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rmid_post[%0d]: got %s, expected %s", i, fmt(o), fmt(e));
            end
            tick();
            if (i == 1) begin
                wr0_req = 1'b0; vga_req = 1'b1;
            end
            if (i == 9) begin
                wr1_req = 1'b0; vga_req = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0; n_fail = 0;
        reset = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        vga_req = 1'b0; vga_x = '0; vga_y = '0;
        wr0_req = 1'b0; wr0_x = '0; wr0_y = '0; wr0_data = '0;
        wr1_req = 1'b0; wr1_x = '0; wr1_y = '0; wr1_data = '0;
        test_reset();
`ifdef CLEAR_ON_RESET_EN
        test_clear();
`endif
        test_vga_read();
        test_round_robin();
        test_vga_priority();
        test_both_starved();
        test_readback();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
